// File: rtl/timer_arbiter.sv
// timer_arbiter: round-robin owner selection for a single shared up-counter.
// The granted requester's terminal count is latched at grant time. The counter
// clears and runs up to that count, and a one-cycle done pulse is returned to
// the owner before the arbiter goes back to idle.
module timer_arbiter #(
    parameter int N = 4,
    parameter int R = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [R-1:0]     req,
    input  logic [R*N-1:0]   tc,
    output logic [R-1:0]     grant,
    output logic [R-1:0]     done,
    output logic             busy,
    output logic [N-1:0]     q
);

    localparam int RW = (R > 1) ? $clog2(R) : 1;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_COUNT = 2'd1;
    localparam logic [1:0] ST_DONE  = 2'd2;

    logic [1:0]    state_q,  state_d;
    logic [R-1:0]  grant_q,  grant_d;
    logic [R-1:0]  done_q,   done_d;
    logic          busy_q,   busy_d;
    logic [N-1:0]  cnt_q,    cnt_d;
    logic [N-1:0]  tc_q,     tc_d;
    logic [RW-1:0] owner_q,  owner_d;
    logic [RW-1:0] rr_ptr_q, rr_ptr_d;

    // Unpacked view of the per-requester terminal counts.
    logic [N-1:0] tc_arr [R];

    generate
        for (genvar gi = 0; gi < R; gi++) begin : g_tc_unpack
            assign tc_arr[gi] = tc[gi*N +: N];
        end
    endgenerate

    logic          pick_valid;
    logic [RW-1:0] pick_idx;
    logic [R-1:0]  pick_onehot;
    logic [RW:0]   scan_sum;
    logic [RW-1:0] next_ptr;

    // The first active request at or above rr_ptr wins, wrapping from R-1 to 0.
    always_comb begin
        pick_valid  = 1'b0;
        pick_idx    = '0;
        pick_onehot = '0;
        scan_sum    = '0;
        for (int i = 0; i < R; i++) begin
            scan_sum = {1'b0, rr_ptr_q} + (RW+1)'(i);
            if (scan_sum >= (RW+1)'(R)) begin
                scan_sum = scan_sum - (RW+1)'(R);
            end
            if (!pick_valid && req[scan_sum[RW-1:0]]) begin
                pick_valid = 1'b1;
                pick_idx   = scan_sum[RW-1:0];
            end
        end
        pick_onehot[pick_idx] = 1'b1;
    end

    // The owner that was just served drops to the lowest priority.
    assign next_ptr = (owner_q == RW'(R-1)) ? '0 : owner_q + RW'(1);

    // Next-state logic: grant, count to the latched terminal count, pulse done.
    always_comb begin
        state_d  = state_q;
        grant_d  = grant_q;
        done_d   = '0;
        busy_d   = busy_q;
        cnt_d    = cnt_q;
        tc_d     = tc_q;
        owner_d  = owner_q;
        rr_ptr_d = rr_ptr_q;
        case (state_q)
            ST_IDLE: begin
                grant_d = '0;
                busy_d  = 1'b0;
                cnt_d   = '0;
                if (pick_valid) begin
                    state_d = ST_COUNT;
                    owner_d = pick_idx;
                    tc_d    = tc_arr[pick_idx];
                    grant_d = pick_onehot;
                    busy_d  = 1'b1;
                end
            end
            ST_COUNT: begin
                if (!req[owner_q]) begin
                    // The owner abandoned its request, so no done pulse is sent.
                    state_d  = ST_IDLE;
                    grant_d  = '0;
                    busy_d   = 1'b0;
                    cnt_d    = '0;
                    rr_ptr_d = next_ptr;
                end else if (cnt_q == tc_q) begin
                    // The counter holds at the terminal count and never wraps.
                    state_d = ST_DONE;
                    done_d  = grant_q;
                end else begin
                    cnt_d = cnt_q + N'(1);
                end
            end
            ST_DONE: begin
                state_d  = ST_IDLE;
                grant_d  = '0;
                busy_d   = 1'b0;
                cnt_d    = '0;
                rr_ptr_d = next_ptr;
            end
            default: begin
                state_d = ST_IDLE;
                grant_d = '0;
                busy_d  = 1'b0;
                cnt_d   = '0;
            end
        endcase
    end

    // State registers. Reset overrides everything, including a count in progress.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            grant_q  <= '0;
            done_q   <= '0;
            busy_q   <= 1'b0;
            cnt_q    <= '0;
            tc_q     <= '0;
            owner_q  <= '0;
            rr_ptr_q <= '0;
        end else begin
            state_q  <= state_d;
            grant_q  <= grant_d;
            done_q   <= done_d;
            busy_q   <= busy_d;
            cnt_q    <= cnt_d;
            tc_q     <= tc_d;
            owner_q  <= owner_d;
            rr_ptr_q <= rr_ptr_d;
        end
    end

    assign grant = grant_q;
    assign done  = done_q;
    assign busy  = busy_q;
    assign q     = cnt_q;

endmodule

// File: tb/tb_timer_arbiter.sv
// Randomized scoreboard bench for timer_arbiter. A timeline model predicts each
// grant (owner, latched tc, length, done offset). A negedge monitor rebuilds
// the observed transaction from the outputs and compares it against that
// prediction.
module tb_timer_arbiter;

    localparam int N     = 4;
    localparam int R     = 4;
    localparam int TCMAX = (1 << N) - 1;
    localparam int NCYC  = 3000;

    logic           clk = 1'b0;
    logic           reset;
    logic [R-1:0]   req;
    logic [R*N-1:0] tc;
    logic [R-1:0]   grant;
    logic [R-1:0]   done;
    logic           busy;
    logic [N-1:0]   q;

    always #5 clk = ~clk;

    timer_arbiter #(.N(N), .R(R)) dut (
        .clk   (clk),
        .reset (reset),
        .req   (req),
        .tc    (tc),
        .grant (grant),
        .done  (done),
        .busy  (busy),
        .q     (q)
    );

    typedef struct {
        int owner;
        int tcv;
        int len;
        int done_off;
    } txn_t;

    txn_t exp_q[$];
    int   n_vec  = 0;
    int   n_miss = 0;
    bit   stim_done = 1'b0;

    task automatic check(input string name, input int act, input int expv);
        n_vec++;
        if (act != expv) begin
            n_miss++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, expv, $time);
        end
    endtask

    // Stimulus plus timeline model. The model uses these rules: a request seen
    // while idle is granted on the next cycle. A grant lasts tc+2 cycles, with
    // done in its last cycle. An abort at offset k, or a reset at offset k,
    // ends the grant after k+1 cycles with no done pulse.
    initial begin
        int             m_ptr, m_owner, m_off, m_len, m_tc, m_abort;
        bit             m_active, rst_v, draining;
        logic [R-1:0]   req_v;
        logic [R*N-1:0] tc_v;
        int             r;
        bit             found;
        m_ptr = 0; m_owner = 0; m_off = 0; m_len = 0; m_tc = 0; m_abort = -1;
        m_active = 1'b0;
        reset = 1'b1; req = '0; tc = '0;
        for (int cyc = 0; cyc < NCYC + 40; cyc++) begin
            draining = (cyc >= NCYC);
            rst_v = (cyc < 3) ||
                    (!draining && m_active && m_off <= m_tc && $urandom_range(0, 49) == 0);
            if (draining || $urandom_range(0, 4) == 0) req_v = '0;
            else req_v = R'($urandom_range(0, (1 << R) - 1));
            for (int i = 0; i < R; i++) begin
                r = int'($urandom_range(0, 7));
                if (r == 0)      tc_v[i*N +: N] = '0;
                else if (r == 1) tc_v[i*N +: N] = N'(TCMAX);
                else             tc_v[i*N +: N] = N'($urandom_range(0, TCMAX));
            end
            if (m_active) begin
                if (m_abort >= 0)       req_v[m_owner] = (m_off < m_abort);
                else if (m_off <= m_tc) req_v[m_owner] = 1'b1;
            end
            reset = rst_v; req = req_v; tc = tc_v;
            @(posedge clk);
            if (rst_v) begin
                if (m_active) exp_q.push_back('{m_owner, m_tc, m_off + 1, -1});
                m_active = 1'b0;
                m_ptr = 0;
            end else if (m_active) begin
                m_off++;
                if (m_off == m_len) begin
                    exp_q.push_back('{m_owner, m_tc, m_len, (m_abort >= 0) ? -1 : m_tc + 1});
                    m_active = 1'b0;
                    m_ptr = (m_owner + 1) % R;
                end
            end else if (req_v != '0) begin
                found = 1'b0;
                for (int i = 0; i < R; i++) begin
                    if (!found && req_v[(m_ptr + i) % R]) begin
                        found = 1'b1;
                        m_owner = (m_ptr + i) % R;
                    end
                end
                m_tc = int'(tc_v[m_owner*N +: N]);
                m_abort = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, m_tc)) : -1;
                m_len = (m_abort >= 0) ? m_abort + 1 : m_tc + 2;
                m_off = 0;
                m_active = 1'b1;
            end
            #1;
        end
        stim_done = 1'b1;
    end

    // Monitor: rebuilds each grant from the outputs and compares it with the scoreboard.
    bit           in_txn = 1'b0;
    logic [R-1:0] obs_grant;
    int           obs_len;
    int           obs_done_off;
    int           q_trace [64];

    always @(negedge clk) begin
        txn_t e;
        int   lim;
        check("grant_onehot0", int'($onehot0(grant)), 1);
        check("done_subset_grant", int'((done & ~grant) != '0), 0);
        if (grant != '0) begin
            if (!in_txn) begin
                in_txn = 1'b1;
                obs_grant = grant;
                obs_len = 0;
                obs_done_off = -1;
            end else begin
                check("grant_stable", int'(grant), int'(obs_grant));
            end
            check("busy_during_grant", int'(busy), 1);
            if (obs_len < 64) q_trace[obs_len] = int'(q);
            if (done != '0) obs_done_off = (obs_done_off == -1) ? obs_len : -2;
            obs_len++;
        end else begin
            check("idle_busy", int'(busy), 0);
            check("idle_q", int'(q), 0);
            if (in_txn) begin
                in_txn = 1'b0;
                if (exp_q.size() == 0) begin
                    n_vec++;
                    n_miss++;
                    $display("FAIL unexpected_grant: got grant=%b, expected no grant", obs_grant);
                end else begin
                    e = exp_q.pop_front();
                    $display("txn owner=%0d tc=%0d len=%0d done_at=%0d (expected len=%0d done_at=%0d)",
                             e.owner, e.tcv, obs_len, obs_done_off, e.len, e.done_off);
                    check("grant_owner", int'(obs_grant), 1 << e.owner);
                    check("grant_len", obs_len, e.len);
                    check("done_offset", obs_done_off, e.done_off);
                    lim = (obs_len < e.len) ? obs_len : e.len;
                    if (lim > 64) lim = 64;
                    for (int k = 0; k < lim; k++) begin
                        check("q_value", q_trace[k], (k < e.tcv) ? k : e.tcv);
                    end
                end
            end
        end
        if (stim_done) begin
            check("scoreboard_drained", exp_q.size(), 0);
            check("txn_closed", int'(in_txn), 0);
            $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
            $finish;
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not complete within the time limit");
        $fatal(1, "watchdog expired");
    end

endmodule
